// File: rtl/fflags_rob_idx_queue_3_if.sv
// Handshake bundle between the fflags producer/consumer and the 3-entry rob_idx queue.
interface fflags_rob_idx_queue_3_if;
  logic       io_enq_valid;
  logic [6:0] io_enq_bits_uop_rob_idx;
  logic [4:0] io_enq_bits_flags;
  logic       io_enq_ready;
  logic       io_deq_ready;
  logic       io_deq_valid;
  logic [6:0] io_deq_bits_uop_rob_idx;
  logic [4:0] io_deq_bits_flags;
  logic       io_flush;
  logic [1:0] io_count;

  modport master (
    output io_enq_valid, io_enq_bits_uop_rob_idx, io_enq_bits_flags, io_deq_ready, io_flush,
    input  io_enq_ready, io_deq_valid, io_deq_bits_uop_rob_idx, io_deq_bits_flags, io_count
  );

  modport slave (
    input  io_enq_valid, io_enq_bits_uop_rob_idx, io_enq_bits_flags, io_deq_ready, io_flush,
    output io_enq_ready, io_deq_valid, io_deq_bits_uop_rob_idx, io_deq_bits_flags, io_count
  );
endinterface

// File: rtl/fflags_rob_idx_queue_3.sv
// 3-entry FIFO of {rob_idx, fflags}; pointer-based, no pipe or flow-through paths.
module fflags_rob_idx_queue_3 (
  input logic                        clock,
  input logic                        reset,
  fflags_rob_idx_queue_3_if.slave    q
);
  typedef struct packed {
    logic [6:0] rob_idx;
    logic [4:0] flags;
  } entry_t;

  entry_t     ram [3];
  logic [1:0] enq_ptr, deq_ptr;
  logic       maybe_full;
  logic       ptr_match, empty, full, do_enq, do_deq;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match && !maybe_full;
  assign full      = ptr_match &&  maybe_full;
  assign do_enq    = q.io_enq_valid && !full  && !q.io_flush;
  assign do_deq    = q.io_deq_ready && !empty && !q.io_flush;

  assign q.io_enq_ready            = !full;
  assign q.io_deq_valid            = !empty;
  assign q.io_deq_bits_uop_rob_idx = ram[deq_ptr].rob_idx;
  assign q.io_deq_bits_flags       = ram[deq_ptr].flags;

  // Modulo-3 distance: adding 3 before wrap keeps the 2-bit subtraction exact.
  always_comb begin
    q.io_count = 2'd0;
    if (full)
      q.io_count = 2'd3;
    else if (enq_ptr >= deq_ptr)
      q.io_count = enq_ptr - deq_ptr;
    else
      q.io_count = enq_ptr - deq_ptr + 2'd3;
  end

  // Storage is deliberately outside reset/flush; outputs are qualified by io_deq_valid.
  always_ff @(posedge clock) begin
    if (do_enq && !reset)
      ram[enq_ptr] <= '{rob_idx: q.io_enq_bits_uop_rob_idx, flags: q.io_enq_bits_flags};
  end

  always_ff @(posedge clock) begin
    if (reset || q.io_flush) begin
      enq_ptr    <= 2'd0;
      deq_ptr    <= 2'd0;
      maybe_full <= 1'b0;
    end else begin
      if (do_enq) enq_ptr <= ptr_inc(enq_ptr);
      if (do_deq) deq_ptr <= ptr_inc(deq_ptr);
      if (do_enq != do_deq) maybe_full <= do_enq;
    end
  end
endmodule

// File: tb/tb_fflags_rob_idx_queue_3.sv
// Randomized and directed check of the 3-entry fflags queue against a queue-based model.
module tb_fflags_rob_idx_queue_3;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  fflags_rob_idx_queue_3_if q ();
  fflags_rob_idx_queue_3 dut (.clock(clock), .reset(reset), .q(q));

  always #5 clock = ~clock;

  // Behavioural model: a plain queue of {rob_idx, flags}.
  logic [11:0] mq[$];
  bit          started = 0;

  always @(posedge clock) begin
    bit ef, df;
    if (reset) begin
      mq.delete();
      started = 1;
    end else if (started) begin
      if (q.io_flush) mq.delete();
      else begin
        ef = q.io_enq_valid && (mq.size() < 3);
        df = q.io_deq_ready && (mq.size() > 0);
        if (df) void'(mq.pop_front());
        if (ef) mq.push_back({q.io_enq_bits_uop_rob_idx, q.io_enq_bits_flags});
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (started && !reset) begin
      chk("m_count", q.io_count, mq.size());
      chk("m_enq_ready", q.io_enq_ready, mq.size() < 3);
      chk("m_deq_valid", q.io_deq_valid, mq.size() > 0);
      if (mq.size() > 0)
        chk("m_deq_bits", {q.io_deq_bits_uop_rob_idx, q.io_deq_bits_flags}, mq[0]);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic ev, input logic [6:0] ri, input logic [4:0] fl,
                        input logic dr, input logic fs);
    q.io_enq_valid = ev;
    q.io_enq_bits_uop_rob_idx = ri;
    q.io_enq_bits_flags = fl;
    q.io_deq_ready = dr;
    q.io_flush = fs;
  endtask

  task automatic idle();
    set_in(1'b0, 7'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    set_in(1'b0, 7'd0, 5'd0, 1'b1, 1'b0);
    repeat (4) cyc();
    idle();
  endtask

  task automatic push(input logic [6:0] ri, input logic [4:0] fl);
    set_in(1'b1, ri, fl, 1'b0, 1'b0);
    cyc();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_count", q.io_count, 0);
    chk("rst_enq_ready", q.io_enq_ready, 1);
    chk("rst_deq_valid", q.io_deq_valid, 0);

    // Fill and drain
    push(7'd5, 5'h01); push(7'd6, 5'h02); push(7'd7, 5'h04);
    idle();
    chk("fill_enq_ready", q.io_enq_ready, 0);
    chk("fill_count", q.io_count, 3);
    q.io_deq_ready = 1'b1;
    chk("drain0", {q.io_deq_bits_uop_rob_idx, q.io_deq_bits_flags}, {7'd5, 5'h01}); cyc();
    chk("drain1", {q.io_deq_bits_uop_rob_idx, q.io_deq_bits_flags}, {7'd6, 5'h02}); cyc();
    chk("drain2", {q.io_deq_bits_uop_rob_idx, q.io_deq_bits_flags}, {7'd7, 5'h04}); cyc();
    chk("drain_empty", q.io_deq_valid, 0);
    idle();

    // Full with both sides active: dequeue fires, enqueue refused
    push(7'd1, 5'h11); push(7'd2, 5'h12); push(7'd3, 5'h13);
    set_in(1'b1, 7'd9, 5'h19, 1'b1, 1'b0);
    cyc();
    idle();
    chk("full_both_count", q.io_count, 2);
    chk("full_both_head", q.io_deq_bits_uop_rob_idx, 2);
    drain();
    chk("full_both_refused", q.io_count, 0);

    // Wrap-around with constant occupancy of 1
    push(7'd20, 5'h00);
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 7'(21 + i), 5'(i), 1'b1, 1'b0);
      cyc();
      chk("wrap_count", q.io_count, 1);
      chk("wrap_head", {q.io_deq_bits_uop_rob_idx, q.io_deq_bits_flags}, {7'(21 + i), 5'(i)});
    end
    drain();

    // Enqueue into empty queue: visible one cycle later
    push(7'h7F, 5'h1F);
    idle();
    chk("empty_enq_valid", q.io_deq_valid, 1);
    chk("empty_enq_bits", {q.io_deq_bits_uop_rob_idx, q.io_deq_bits_flags}, {7'h7F, 5'h1F});
    chk("empty_enq_count", q.io_count, 1);
    drain();

    // Flush overrides a concurrent enqueue
    push(7'd40, 5'h03); push(7'd41, 5'h04);
    set_in(1'b1, 7'd42, 5'h05, 1'b1, 1'b1);
    cyc();
    idle();
    chk("flush_count", q.io_count, 0);
    chk("flush_deq_valid", q.io_deq_valid, 0);
    chk("flush_enq_ready", q.io_enq_ready, 1);

    // Mid-operation reset
    push(7'd50, 5'h01); push(7'd51, 5'h02); push(7'd52, 5'h03);
    idle();
    reset = 1'b1;
    set_in(1'b1, 7'd60, 5'h06, 1'b1, 1'b0);
    cyc();
    reset = 1'b0;
    idle();
    chk("mrst_count", q.io_count, 0);
    chk("mrst_deq_valid", q.io_deq_valid, 0);
    chk("mrst_enq_ready", q.io_enq_ready, 1);
    push(7'h33, 5'h0A);
    idle();
    chk("mrst_readback", {q.io_deq_bits_uop_rob_idx, q.io_deq_bits_flags}, {7'h33, 5'h0A});
    drain();

    // Random traffic, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      set_in(1'($urandom_range(0, 1)), 7'($urandom), 5'($urandom),
             1'($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
      reset = ($urandom_range(0, 127) == 0);
      cyc();
    end
    reset = 1'b0;
    idle();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
